// File: rtl/dcache_controller_if.sv
// CPU data-memory port and off-chip line-memory port of the data cache.
// The slave modport is the cache's view; master is the CPU/memory side.
interface dcache_controller_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LINE_BITS = 256
);
    logic [ADDR_W-1:0]    p1_addr_i;
    logic [DATA_W-1:0]    p1_data_i;
    logic                 p1_MemRead_i;
    logic                 p1_MemWrite_i;
    logic [DATA_W-1:0]    p1_data_o;
    logic                 p1_stall_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_o;
    logic                 mem_enable_o;
    logic                 mem_write_o;
    logic [LINE_BITS-1:0] mem_data_i;
    logic                 mem_ack_i;

    modport slave (
        input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        input  mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport master (
        output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        output mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and off-chip memory: zero-stall hits, write-back of dirty victims, line refill.
module dcache_controller #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_controller_if.slave  io_bus
);
    localparam int IW    = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 5 - IW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0] r_data [NUM_LINES];

    logic [IW-1:0]    w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [2:0]       w_wsel;
    logic             w_req;
    logic             w_store;
    logic             w_hit;
    logic             w_fill;
    logic             w_store_hit;
    logic             w_unused;

    assign w_idx    = io_bus.p1_addr_i[5+IW-1:5];
    assign w_tag    = io_bus.p1_addr_i[ADDR_W-1:5+IW];
    assign w_wsel   = io_bus.p1_addr_i[4:2];
    assign w_unused = ^io_bus.p1_addr_i[1:0];

    // A simultaneous read+write request is a store.
    assign w_req       = io_bus.p1_MemRead_i | io_bus.p1_MemWrite_i;
    assign w_store     = io_bus.p1_MemWrite_i;
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill      = (r_state == S_REFILL) && io_bus.mem_ack_i;
    assign w_store_hit = (r_state == S_IDLE) && w_req && w_store && w_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_store_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tag/data storage carries no reset; the valid bits gate its use.
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= io_bus.mem_data_i;
        end else if (w_store_hit) begin
            r_data[w_idx][int'(w_wsel)*DATA_W +: DATA_W] <= io_bus.p1_data_i;
        end
    end

    always_comb begin
        w_next              = r_state;
        io_bus.p1_data_o    = '0;
        io_bus.p1_stall_o   = 1'b0;
        io_bus.mem_addr_o   = '0;
        io_bus.mem_data_o   = '0;
        io_bus.mem_enable_o = 1'b0;
        io_bus.mem_write_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        if (!w_store) begin
                            io_bus.p1_data_o = r_data[w_idx][int'(w_wsel)*DATA_W +: DATA_W];
                        end
                    end else begin
                        io_bus.p1_stall_o = 1'b1;
                        w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_REFILL;
                    end
                end
            end
            S_WRITEBACK: begin
                io_bus.p1_stall_o   = 1'b1;
                io_bus.mem_enable_o = 1'b1;
                io_bus.mem_write_o  = 1'b1;
                io_bus.mem_addr_o   = {r_tag[w_idx], w_idx, 5'b0};
                io_bus.mem_data_o   = r_data[w_idx];
                if (io_bus.mem_ack_i) begin
                    w_next = S_REFILL;
                end
            end
            S_REFILL: begin
                io_bus.p1_stall_o   = 1'b1;
                io_bus.mem_enable_o = 1'b1;
                io_bus.mem_addr_o   = {w_tag, w_idx, 5'b0};
                if (io_bus.mem_ack_i) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                io_bus.p1_stall_o = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: latency-programmable line memory, architectural
// word-memory reference model, and directed access sequences.
module tb_dcache_controller;
    logic clk;
    logic rst;
    int   lat;
    int   n_checks;
    int   n_fail;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [255:0] line;
    } txn_t;

    txn_t         log_q [$];
    logic [255:0] backing [logic [31:0]];
    logic [31:0]  ovr [logic [31:0]];

    dcache_controller_if #(.ADDR_W(32), .DATA_W(32), .LINE_BITS(256)) bus ();

    dcache_controller #(
        .NUM_LINES(32),
        .LINE_BITS(256),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .io_bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = (la + 32'(4 * i)) ^ 32'h5A00_0000;
        end
        return l;
    endfunction

    // Architectural value of a word: last committed store, else backing memory.
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0]  la;
        logic [255:0] l;
        if (ovr.exists(a)) begin
            return ovr[a];
        end
        la = {a[31:5], 5'b0};
        l  = backing.exists(la) ? backing[la] : init_line(la);
        return l[int'(a[4:2])*32 +: 32];
    endfunction

    // Line memory: ack in the lat-th enable cycle.
    initial begin
        int          cnt;
        logic [31:0] a;
        cnt = 0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack_i = 1'b0;
            if (rst || !bus.mem_enable_o) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= lat) begin
                    cnt = 0;
                    a = bus.mem_addr_o;
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_write_o) begin
                        for (int i = 0; i < 8; i++) begin
                            chk("writeback word", bus.mem_data_o[i*32 +: 32], ref_word(a + 32'(4 * i)));
                        end
                        backing[a] = bus.mem_data_o;
                        log_q.push_back('{1'b1, a, bus.mem_data_o});
                    end else begin
                        bus.mem_data_i = backing.exists(a) ? backing[a] : init_line(a);
                        log_q.push_back('{1'b0, a, bus.mem_data_i});
                    end
                end
            end
        end
    end

    // Per-cycle compare against the architectural model.
    initial begin
        bit          prev_en;
        bit          prev_ack;
        bit          prev_wr;
        logic [31:0] prev_addr;
        bit          req;
        prev_en = 1'b0;
        prev_ack = 1'b0;
        prev_wr = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ovr.delete();
                prev_en = 1'b0;
                continue;
            end
            req = bus.p1_MemRead_i || bus.p1_MemWrite_i;
            if (req && !bus.p1_stall_o) begin
                if (bus.p1_MemWrite_i) begin
                    ovr[bus.p1_addr_i] = bus.p1_data_i;
                end else begin
                    chk("load data", bus.p1_data_o, ref_word(bus.p1_addr_i));
                end
            end
            if (!req) begin
                chk("idle outputs",
                    {bus.p1_stall_o, bus.p1_data_o, bus.mem_enable_o, bus.mem_write_o,
                     bus.mem_addr_o, bus.mem_data_o}, '0);
            end
            if (bus.mem_enable_o) begin
                chk("mem request shape", {bus.p1_stall_o, bus.mem_addr_o[4:0]}, {1'b1, 5'b0});
            end
            if (prev_en && !prev_ack) begin
                chk("mem request held", {bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o},
                    {1'b1, prev_wr, prev_addr});
            end
            prev_en   = bus.mem_enable_o;
            prev_ack  = bus.mem_ack_i;
            prev_wr   = bus.mem_write_o;
            prev_addr = bus.mem_addr_o;
        end
    end

    task automatic access(input logic [31:0] a, input logic [31:0] d, input bit wr, input bit both,
                          input int exp_stall, input string nm, output logic [31:0] rdata);
        int n;
        @(posedge clk);
        #2;
        bus.p1_addr_i     = a;
        bus.p1_data_i     = d;
        bus.p1_MemRead_i  = !wr || both;
        bus.p1_MemWrite_i = wr;
        n = 0;
        @(negedge clk);
        while (bus.p1_stall_o === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({nm, " stall cycles"}, n, exp_stall);
        rdata = bus.p1_data_o;
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0]  rd;
        logic [255:0] l;
        int           k;
        n_checks = 0;
        n_fail   = 0;
        lat      = 10;
        rst      = 1'b1;
        bus.p1_addr_i     = '0;
        bus.p1_data_i     = '0;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
        l = init_line(32'h40);
        l[31:0] = 32'hDEAD_BEEF;
        backing[32'h40] = l;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("reset outputs",
            {bus.p1_stall_o, bus.p1_data_o, bus.mem_enable_o, bus.mem_write_o,
             bus.mem_addr_o, bus.mem_data_o}, '0);

        // Clean read miss, L=10
        log_q.delete();
        access(32'h40, 32'h0, 1'b0, 1'b0, 12, "clean read miss", rd);
        chk("clean miss data", rd, 32'hDEAD_BEEF);
        chk("clean miss request count", log_q.size(), 1);
        chk("clean miss request", {log_q[0].wr, log_q[0].addr}, {1'b0, 32'h40});
        idle();

        // Write hit, then read it back
        access(32'h44, 32'h1234_5678, 1'b1, 1'b0, 0, "write hit", rd);
        access(32'h44, 32'h0, 1'b0, 1'b0, 0, "read after write hit", rd);
        chk("read after write hit data", rd, 32'h1234_5678);
        idle();

        // Dirty eviction at index 2
        log_q.delete();
        access(32'h440, 32'h0, 1'b0, 1'b0, 22, "dirty eviction", rd);
        chk("dirty eviction data", rd, 32'h5A00_0440);
        chk("dirty eviction request count", log_q.size(), 2);
        chk("dirty eviction writeback", {log_q[0].wr, log_q[0].addr}, {1'b1, 32'h40});
        chk("dirty eviction word1", log_q[0].line[63:32], 32'h1234_5678);
        chk("dirty eviction word0", log_q[0].line[31:0], 32'hDEAD_BEEF);
        chk("dirty eviction refill", {log_q[1].wr, log_q[1].addr}, {1'b0, 32'h440});
        idle();

        // Store miss with clean victim, then conflicting access to index 0
        log_q.delete();
        access(32'h808, 32'hCAFE_F00D, 1'b1, 1'b0, 12, "store miss", rd);
        chk("store miss request", {log_q.size(), log_q[0].wr, log_q[0].addr}, {32'd1, 1'b0, 32'h800});
        access(32'h808, 32'h0, 1'b0, 1'b0, 0, "read merged word", rd);
        chk("merged word data", rd, 32'hCAFE_F00D);
        log_q.delete();
        access(32'h008, 32'h0, 1'b0, 1'b0, 22, "store miss eviction", rd);
        chk("store miss eviction data", rd, 32'h5A00_0008);
        chk("store miss writeback", {log_q[0].wr, log_q[0].addr}, {1'b1, 32'h800});
        chk("store miss writeback word2", log_q[0].line[95:64], 32'hCAFE_F00D);

        // Back-to-back misses to different lines
        access(32'h44, 32'h0, 1'b0, 1'b0, 12, "back-to-back first", rd);
        chk("back-to-back first data", rd, 32'h1234_5678);
        access(32'h1000, 32'h0, 1'b0, 1'b0, 12, "back-to-back second", rd);
        chk("back-to-back second data", rd, 32'h5A00_1000);

        // Reset during REFILL
        @(posedge clk);
        #2;
        bus.p1_addr_i     = 32'h2000;
        bus.p1_MemRead_i  = 1'b1;
        bus.p1_MemWrite_i = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(bus.mem_enable_o && !bus.mem_write_o) && k < 50);
        chk("refill reached", k < 50, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.p1_MemRead_i = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("after reset enable/stall", {bus.mem_enable_o, bus.p1_stall_o}, 2'b00);
        access(32'h44, 32'h0, 1'b0, 1'b0, 12, "miss after reset", rd);
        chk("miss after reset data", rd, 32'h1234_5678);
        access(32'h2000, 32'h0, 1'b0, 1'b0, 12, "repeat aborted load", rd);
        chk("repeat aborted load data", rd, 32'h5A00_2000);
        idle();

        // Minimum latency L=1
        lat = 1;
        access(32'h3000, 32'h0, 1'b0, 1'b0, 3, "min latency clean miss", rd);
        chk("min latency data", rd, 32'h5A00_3000);
        access(32'h3004, 32'hB0B0_1111, 1'b1, 1'b1, 0, "read+write store hit", rd);
        log_q.delete();
        access(32'h2000, 32'h0, 1'b0, 1'b0, 4, "min latency dirty miss", rd);
        chk("min latency dirty writeback", {log_q[0].wr, log_q[0].addr, log_q[0].line[63:32]},
            {1'b1, 32'h3000, 32'hB0B0_1111});
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache between the CPU's MEM stage (data-memory port) and the off-chip data memory. Serves loads and stores from on-chip line storage with zero stall on a hit. On a miss it holds the pipeline via a stall output, writes back a dirty victim, refills the line, then completes the access. Sits directly downstream of the CPU's data-memory port; the MEM/WB register captures its read data.

## Interface
- `NUM_LINES`, 32, number of cache lines (power of two); index width `IW = log2(NUM_LINES)`.
- `LINE_BITS`, 256, line size in bits (32 bytes, 8 words).
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, CPU word width.
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `p1_addr_i`  in  ADDR_W  CPU byte address (word aligned).
- `p1_data_i`  in  DATA_W  store data.
- `p1_MemRead_i`  in  1  load request.
- `p1_MemWrite_i`  in  1  store request.
- `p1_data_o`  out  DATA_W  load data, valid while the request is present and `p1_stall_o` is 0.
- `p1_stall_o`  out  1  freeze pipeline; combinational from request plus state.
- `mem_addr_o`  out  ADDR_W  line-aligned memory address.
- `mem_data_o`  out  LINE_BITS  write-back line data.
- `mem_enable_o`  out  1  memory request valid.
- `mem_write_o`  out  1  1 = write line, 0 = read line.
- `mem_data_i`  in  LINE_BITS  refill data, valid in the `mem_ack_i` cycle.
- `mem_ack_i`  in  1  single-cycle completion pulse from memory.

## Operation
- Address split:
  - offset = `addr[4:0]`; word select = `addr[4:2]`.
  - index = `addr[5+IW-1:5]`.
  - tag = `addr[ADDR_W-1:5+IW]` (22 bits at defaults).
- Per-line state: valid, dirty, tag, and LINE_BITS data.
- Request = `p1_MemRead_i | p1_MemWrite_i`. If both are asserted, the access is treated as a store.
- Hit = valid & tag match at index.
- States are IDLE, WRITEBACK, REFILL and DONE.
- IDLE:
  - Read hit: `p1_data_o` = selected word, stall 0.
  - Write hit: the selected word is replaced at the edge and dirty is set; stall 0.
  - Miss: stall 1. Next state is WRITEBACK if the victim is valid & dirty, else REFILL.
  - No request: stall 0 and `p1_data_o` = 0.
- WRITEBACK:
  - `mem_enable_o`=1, `mem_write_o`=1.
  - `mem_addr_o` = {victim tag, index, 5'b0}; `mem_data_o` = victim line.
  - On `mem_ack_i`, go to REFILL.
- REFILL:
  - `mem_enable_o`=1, `mem_write_o`=0.
  - `mem_addr_o` = {request tag, index, 5'b0}.
  - On `mem_ack_i`, install `mem_data_i`, tag, valid=1, dirty=0, then go to DONE.
- DONE:
  - Stall stays 1; next state is IDLE.
  - In IDLE the access re-evaluates as a hit and completes. A store miss therefore merges its word and sets dirty in that IDLE cycle.
- In all non-IDLE states `p1_stall_o`=1. CPU inputs must be held stable while stalled; the controller latches nothing from them.
- Outside WRITEBACK/REFILL: `mem_enable_o`, `mem_write_o` = 0; `mem_addr_o`, `mem_data_o` = 0.
- Memory handshake:
  - The request is held with all fields stable until the `mem_ack_i` cycle.
  - Enable drops (or switches to the refill request) on the following cycle.
  - `mem_ack_i` outside WRITEBACK/REFILL is ignored.

## Timing
- Reset: state IDLE; all valid and dirty bits cleared. Tag and data arrays need no reset.
- Outputs with no request pending after reset: `p1_stall_o`=0, `p1_data_o`=0, all `mem_*_o`=0.
- Reset mid-transfer (WRITEBACK/REFILL) aborts: the next cycle is IDLE and the enable is low. Dirty data in flight is lost.
- Hit latency: 0 stall cycles; read data is combinational in the request cycle.
- Memory latency L: ack arrives in the L-th cycle of enable assertion (L ≥ 1).
- Clean miss presented in cycle 0:
  - Stall high in cycles 0 through L+1.
  - Enable high in cycles 1 through L.
  - Access completes in cycle L+2.
- Dirty miss:
  - Write-back enable high in cycles 1 through L.
  - Refill enable high in cycles L+1 through 2L.
  - DONE in cycle 2L+1; access completes in cycle 2L+2.
- Ack in the first enable cycle (L=1) is legal.
- Ack is a pulse; a held-high ack would complete WRITEBACK and REFILL on consecutive cycles and is not used by the memory model.
- Back-to-back accesses to different lines with no idle cycle between them are supported.

## Test plan
- Clean read miss:
  - Stimulus: after reset, load 0x0000_0040 with memory L=10 and line word 0 = 0xDEAD_BEEF.
  - Response: stall for 12 cycles, one read request to 0x40, then `p1_data_o`=0xDEAD_BEEF with stall 0.
- Write hit sets dirty:
  - Stimulus: store 0x1234_5678 to 0x44, then load 0x44.
  - Response: no stall on either access; load returns 0x1234_5678.
- Dirty eviction:
  - Stimulus: load 0x0000_0440 (same index, different tag).
  - Response:
    - Write request to 0x40 whose line word 1 = 0x1234_5678.
    - Then a read request to 0x440.
    - Stall totals 2L+2 cycles.
- Store miss:
  - Stimulus: store 0xCAFE_F00D to 0x0000_0808, clean victim.
  - Response: refill, then word 2 is merged and dirty is set. A later conflicting access to index 0 writes back a line with word 2 = 0xCAFE_F00D.
- Reset mid-operation:
  - Stimulus: assert `rst_i` for one cycle during REFILL.
  - Response: the next cycle is IDLE with `mem_enable_o`=0. Repeating the load misses again.
- Minimum latency:
  - Stimulus: clean miss with L=1.
  - Response: stall exactly 3 cycles.
